// File: rtl/rom_sequencer.sv
// Steps through a 1-cycle-latency ROM, holding each word on o_data_out for DUR cycles.
// Optional build macro ROM_SEQUENCER_EOS_EN: an all-zero word ends the sequence.
module rom_sequencer #(
  parameter int unsigned AW  = 5,
  parameter int unsigned DW  = 4,
  parameter int unsigned DUR = 3000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_loop,
  input  logic [DW-1:0] i_rom_data,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data_out,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned CW = $clog2(DUR) + 1;
  localparam logic [AW-1:0] LastAddr = '1;

  typedef enum logic [1:0] {StIdle, StFetch1, StFetch2, StPlay} state_e;

  state_e        r_state;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      // Abort wins over every other transition once playback has begun.
      if (r_state != StIdle && i_stop) begin
        r_state <= StIdle;
        r_addr  <= '0;
        r_data  <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start && !i_stop) begin
              r_addr  <= '0;
              r_state <= StFetch1;
              r_busy  <= 1'b1;
            end
          end
          StFetch1: r_state <= StFetch2;
          StFetch2: begin
            r_cnt <= '0;
`ifdef ROM_SEQUENCER_EOS_EN
            if (i_rom_data == '0) begin
              if (i_loop) begin
                r_addr  <= '0;
                r_state <= StFetch1;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
            end else begin
              r_data  <= i_rom_data;
              r_valid <= 1'b1;
              r_state <= StPlay;
            end
`else
            r_data  <= i_rom_data;
            r_valid <= 1'b1;
            r_state <= StPlay;
`endif
          end
          StPlay: begin
            if (r_cnt == CW'(DUR - 1)) begin
              r_cnt <= '0;
              if (r_addr != LastAddr || i_loop) begin
                // Increment wraps to 0 after the last address when looping.
                r_addr  <= r_addr + AW'(1);
                r_state <= StFetch1;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_data_out = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed timing scenarios plus randomized control checked
// every cycle against a step/phase reference model.
module tb_rom_sequencer;
  localparam int AW = 2, DW = 4, DUR = 3, NPOS = 4;
`ifdef ROM_SEQUENCER_EOS_EN
  localparam bit EOS = 1'b1;
`else
  localparam bit EOS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, stop, loop;
  logic [DW-1:0] rom_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic valid, busy, done;
  logic [DW-1:0] rom [NPOS];

  rom_sequencer #(.AW(AW), .DW(DW), .DUR(DUR)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_rom_data(rom_data), .o_addr(addr), .o_data_out(data_out), .o_valid(valid),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[addr];

  int total = 0, bad = 0, cyc = 0;
  bit m_busy = 0, m_valid = 0, m_done = 0;
  int m_pos = 0, m_ph = 0, m_addr = 0, m_data = 0;
  int vq[$], vd[$];
  int done_cyc, busy_first, busy_last, max_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: a step is FETCH (2 cycles) then DUR play cycles; m_ph counts cycles into the step.
  task automatic model_edge();
    m_valid = 0;
    m_done  = 0;
    if (rst) begin
      m_busy = 0; m_addr = 0; m_data = 0; m_ph = 0; m_pos = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_pos = 0; m_ph = 0; m_addr = 0;
      end
    end else if (stop) begin
      m_busy = 0; m_addr = 0; m_data = 0;
    end else begin
      m_ph++;
      if (m_ph == 2) begin
        if (EOS && rom[m_pos] == 0) begin
          if (loop) begin
            m_pos = 0; m_ph = 0; m_addr = 0;
          end else begin
            m_busy = 0; m_done = 1;
          end
        end else begin
          m_data = rom[m_pos];
          m_valid = 1;
        end
      end else if (m_ph == DUR + 2) begin
        if (m_pos < NPOS - 1) begin
          m_pos++; m_ph = 0; m_addr = m_pos;
        end else if (loop) begin
          m_pos = 0; m_ph = 0; m_addr = 0;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("addr", 32'(addr), 32'(m_addr));
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    if (valid === 1'b1) begin
      vq.push_back(cyc);
      vd.push_back(int'(data_out));
    end
    if (done === 1'b1) done_cyc = cyc;
    if (busy === 1'b1) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (int'(addr) > max_addr) max_addr = int'(addr);
  endtask

  // Leaves start high; caller steps once (cycle 1 = FETCH1) and drops it.
  task automatic begin_run();
    vq.delete();
    vd.delete();
    cyc = 0; done_cyc = -1; busy_first = -1; busy_last = -1; max_addr = 0;
    start = 1;
  endtask

  task automatic do_reset();
    rst = 1; start = 0; stop = 0; loop = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic check_base_timing(input string tag);
    check_eq({tag, "_nvalid"}, 32'(vq.size()), 32'd4);
    for (int i = 0; i < 4 && i < vq.size(); i++) begin
      check_eq({tag, "_vcyc"}, 32'(vq[i]), 32'(3 + 5 * i));
      check_eq({tag, "_vdata"}, 32'(vd[i]), 32'(i + 1));
    end
    check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'd21);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; loop = 0;
    for (int i = 0; i < NPOS; i++) rom[i] = DW'(i + 1);

    // Reset state and the basic four-step sequence.
    do_reset();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_addr", 32'(addr), 32'd0);
    begin_run();
    step();
    start = 0;
    repeat (22) step();
    check_base_timing("base");
    check_eq("base_busy_first", 32'(busy_first), 32'd1);
    check_eq("base_busy_last", 32'(busy_last), 32'd20);

    // Looping wraps to address 0 without a done pulse.
    loop = 1;
    begin_run();
    step();
    start = 0;
    repeat (24) step();
    check_eq("loop_nvalid", 32'(vq.size()), 32'd5);
    if (vq.size() >= 5) begin
      check_eq("loop_vcyc", 32'(vq[4]), 32'd23);
      check_eq("loop_vdata", 32'(vd[4]), 32'd1);
    end
    check_eq("loop_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    loop = 0;
    stop = 1;
    step();
    stop = 0;

    // Stop mid-playback.
    begin_run();
    step();
    start = 0;
    while (cyc < 10) step();
    stop = 1;
    step();
    stop = 0;
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_addr", 32'(addr), 32'd0);
    check_eq("stop_data", 32'(data_out), 32'd0);
    repeat (15) step();
    check_eq("stop_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

    // Start while busy is ignored.
    begin_run();
    step();
    start = 0;
    while (cyc < 6) step();
    start = 1;
    step();
    start = 0;
    repeat (16) step();
    check_base_timing("restart_ign");

    // Reset mid-playback with start held, then restart on release.
    begin_run();
    step();
    start = 0;
    while (cyc < 9) step();
    rst = 1;
    start = 1;
    step();
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_addr", 32'(addr), 32'd0);
    check_eq("rst_mid_data", 32'(data_out), 32'd0);
    check_eq("rst_mid_valid", 32'(valid), 32'd0);
    rst = 0;
    begin_run();
    step();
    start = 0;
    repeat (22) step();
    check_base_timing("rst_release");

    // Zero word in the ROM.
    rom[0] = 4'd5; rom[1] = 4'd0; rom[2] = 4'd7; rom[3] = 4'd8;
    begin_run();
    step();
    start = 0;
    repeat (22) step();
    if (EOS) begin
      check_eq("eos_nvalid", 32'(vq.size()), 32'd1);
      if (vq.size() >= 1) begin
        check_eq("eos_vcyc", 32'(vq[0]), 32'd3);
        check_eq("eos_vdata", 32'(vd[0]), 32'd5);
      end
      check_eq("eos_done_cyc", 32'(done_cyc), 32'd8);
      check_eq("eos_max_addr", 32'(max_addr), 32'd1);
    end else begin
      check_eq("zero_nvalid", 32'(vq.size()), 32'd4);
      for (int i = 0; i < 4 && i < vq.size(); i++)
        check_eq("zero_vdata", 32'(vd[i]), 32'(rom[i]));
      check_eq("zero_done_cyc", 32'(done_cyc), 32'd21);
    end

    // Randomized control against the model, with zero-rich ROM contents.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < NPOS; i++)
        rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : DW'($urandom_range(1, 15));
      do_reset();
      repeat (1500) begin
        rst   = ($urandom_range(0, 199) == 0);
        stop  = ($urandom_range(0, 39) == 0);
        start = ($urandom_range(0, 3) == 0);
        loop  = $urandom_range(0, 1) == 1;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 SHALL have parameter AW, default 5, address width in bits (sequence length NPOS = 2**AW).
REQ-002 SHALL have parameter DW, default 4, data width in bits.
REQ-003 SHALL have parameter DUR, default 3000000, hold time per step in clk cycles (minimum 1).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; sampled in IDLE only; begins playback at address 0.
REQ-007 stop  input  1  level; aborts playback from any state.
REQ-008 loop  input  1  level; sampled at end of last step; 1 = wrap to address 0.
REQ-009 addr  output  AW  registered ROM address, drives the 1-cycle-latency ROM address port.
REQ-010 rom_data  input  DW  ROM read data, valid the cycle after addr is presented.
REQ-011 data_out  output  DW  registered current step value.
REQ-012 valid  output  1  one-cycle pulse when data_out takes a new value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at natural end of a non-looping sequence.

Function
REQ-015 SHALL implement states IDLE, FETCH1, FETCH2, PLAY.
REQ-016 IDLE: start=1 and stop=0 -> addr<=0, FETCH1; otherwise stay.
REQ-017 FETCH1: addr held stable one cycle (ROM samples it) -> FETCH2.
REQ-018 FETCH2: data_out<=rom_data, hold counter<=0 -> PLAY; valid=1 in the first PLAY cycle only.
REQ-019 PLAY: counter increments each cycle; PLAY lasts exactly DUR cycles; start→first valid latency is 3 cycles; step period is DUR+2 cycles.
REQ-020 End of PLAY with addr<NPOS-1 -> addr<=addr+1, FETCH1.
REQ-021 End of PLAY with addr=NPOS-1 and loop=1 -> addr wraps to 0, FETCH1, no done pulse.
REQ-022 End of PLAY with addr=NPOS-1 and loop=0 -> done=1 for one cycle, IDLE; data_out retains last value.
REQ-023 stop=1 in any non-IDLE state -> IDLE next cycle, addr<=0, data_out<=0, no done pulse; stop has priority over start, loop and step advance.
REQ-024 start asserted while busy SHALL be ignored; start held high in IDLE after done SHALL restart on the next cycle.
REQ-025 Counter width SHALL be clog2(DUR)+1 bits; addr increment SHALL be modulo 2**AW.

Reset
REQ-026 rst=1 SHALL force on next edge: IDLE, addr=0, data_out=0, counter=0, valid=0, busy=0, done=0.
REQ-027 rst mid-playback SHALL abort with no done pulse; rst SHALL override stop and start.

Configuration
REQ-028 Macro ROM_SEQUENCER_EOS_EN defined: a FETCH2 word equal to all-zeros SHALL be an end-of-sequence marker: not loaded into data_out, no valid; loop=1 -> addr<=0, FETCH1; loop=0 -> done pulse, IDLE.
REQ-029 Macro ROM_SEQUENCER_EOS_EN undefined: zero words SHALL be played as ordinary data; end only at addr=NPOS-1.

Verification (AW=2, DW=4, DUR=3, ROM = 1,2,3,4, bench ROM model with 1-cycle latency)
REQ-030 rst then start pulse at cycle 0 -> valid at cycles 3,8,13,18 with data_out 1,2,3,4; done at cycle 21; busy cycles 1-20.
REQ-031 loop=1, start -> after data_out=4 holds 3 cycles, addr returns to 0, data_out=1 with valid at cycle 23, no done.
REQ-032 stop=1 at cycle 10 -> cycle 11: IDLE, busy=0, addr=0, data_out=0, done never asserted.
REQ-033 start pulsed again at cycle 6 while busy -> sequence timing identical to REQ-030.
REQ-034 rst=1 at cycle 9 with start=1 -> all outputs zero next cycle; release rst with start=1 -> playback restarts from addr 0, first valid 3 cycles after release.
REQ-035 ROM_SEQUENCER_EOS_EN defined, ROM = 5,0,7,8, loop=0 -> valid only for data_out=5 at cycle 3, done at cycle 8, addr 2 never issued; undefined -> data_out 5,0,7,8 all with valid.
